// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace buffer: capture state encoding.
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// A same-cycle read of the slot being written returns the previous contents.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 160,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Trace capture of PC plus per-stage instruction words into a circular buffer,
// with arm/trigger/post-trigger control and a registered, oldest-first read port.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STAGES    = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1,
    localparam int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   sample_en,
    input  logic                   trig_en,
    input  logic [XLEN-1:0]        trig_pc,
    input  logic                   force_trig,
    input  logic [XLEN-1:0]        pc,
    input  logic [STAGES*XLEN-1:0] stage_instr,
    input  logic [AW-1:0]          rd_addr,
    input  logic [SW-1:0]          rd_stage,
    output logic [XLEN-1:0]        rd_pc,
    output logic [XLEN-1:0]        rd_instr,
    output logic                   rd_valid,
    output logic [1:0]             state,
    output logic [CW-1:0]          count,
    output logic [AW-1:0]          trig_idx
);

    localparam int WW = XLEN * (STAGES + 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   post_cnt_q, post_cnt_d;
    logic [AW-1:0]   trig_slot_q, trig_slot_d;
    logic [SW-1:0]   rd_stage_q, rd_stage_d;
    logic            rd_valid_q, rd_valid_d;

    logic            trig_hit;
    logic            wr_en;
    logic            full;
    logic [AW-1:0]   base;
    logic [AW-1:0]   raddr;
    logic [WW-1:0]   rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (trig_hit) begin
                        state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (sample_en && post_cnt_q == AW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        trig_hit = sample_en & ((trig_en & (pc == trig_pc)) | force_trig);
        wr_en    = sample_en & ~arm & ((state_q == ST_ARMED) | (state_q == ST_POST));
        full     = (count_q == CW'(DEPTH));
        // Once the buffer has wrapped, the oldest sample sits at the write pointer.
        base     = full ? wr_ptr_q : '0;
        raddr    = base + rd_addr;

        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        trig_slot_d = trig_slot_q;
        if (arm) begin
            wr_ptr_d    = '0;
            count_d     = '0;
            post_cnt_d  = '0;
            trig_slot_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = full ? count_q : count_q + CW'(1);
            if (state_q == ST_ARMED && trig_hit) begin
                post_cnt_d  = AW'(POST_TRIG);
                trig_slot_d = wr_ptr_q;
            end else if (state_q == ST_POST) begin
                post_cnt_d = post_cnt_q - AW'(1);
            end
        end

        rd_stage_d = rd_stage;
        rd_valid_d = ({1'b0, rd_addr} < count_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            trig_slot_q <= '0;
            rd_stage_q  <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            trig_slot_q <= trig_slot_d;
            rd_stage_q  <= rd_stage_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Entry layout: PC in the low word, stage k in word k+1.
    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({stage_instr, pc}),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        rd_pc    = rdata[XLEN-1:0];
        rd_instr = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (rd_stage_q == SW'(k)) begin
                rd_instr = rdata[XLEN*(k+1) +: XLEN];
            end
        end
        rd_valid = rd_valid_q;
        state    = state_q;
        count    = count_q;
        trig_idx = trig_slot_q - base;
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: read-back vector tables per scenario
// plus hand-written sequences for arm collision and asynchronous reset.
module tb_pipe_trace_buffer;

    localparam int XLEN   = 32;
    localparam int STAGES = 4;
    localparam int DEPTH  = 16;

    logic                   clk         = 1'b0;
    logic                   reset       = 1'b0;
    logic                   arm         = 1'b0;
    logic                   sample_en   = 1'b0;
    logic                   trig_en     = 1'b0;
    logic                   force_trig  = 1'b0;
    logic [XLEN-1:0]        trig_pc     = '0;
    logic [XLEN-1:0]        pc          = '0;
    logic [STAGES*XLEN-1:0] stage_instr = '0;
    logic [3:0]             rd_addr     = '0;
    logic [1:0]             rd_stage    = '0;

    logic [XLEN-1:0] a_rd_pc, a_rd_instr, b_rd_pc, b_rd_instr;
    logic            a_rd_valid, b_rd_valid;
    logic [1:0]      a_state, b_state;
    logic [4:0]      a_count, b_count;
    logic [3:0]      a_trig_idx, b_trig_idx;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int          dut;
        int          phase;
        logic [3:0]  addr;
        logic [1:0]  stg;
        logic [31:0] pc;
        logic        chk_data;
        logic        valid;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pipe_trace_buffer #(.XLEN(XLEN), .STAGES(STAGES), .DEPTH(DEPTH), .POST_TRIG(8)) dut_a (
        .clk(clk), .reset(reset), .arm(arm), .sample_en(sample_en), .trig_en(trig_en),
        .trig_pc(trig_pc), .force_trig(force_trig), .pc(pc), .stage_instr(stage_instr),
        .rd_addr(rd_addr), .rd_stage(rd_stage), .rd_pc(a_rd_pc), .rd_instr(a_rd_instr),
        .rd_valid(a_rd_valid), .state(a_state), .count(a_count), .trig_idx(a_trig_idx)
    );

    pipe_trace_buffer #(.XLEN(XLEN), .STAGES(STAGES), .DEPTH(DEPTH), .POST_TRIG(0)) dut_b (
        .clk(clk), .reset(reset), .arm(arm), .sample_en(sample_en), .trig_en(trig_en),
        .trig_pc(trig_pc), .force_trig(force_trig), .pc(pc), .stage_instr(stage_instr),
        .rd_addr(rd_addr), .rd_stage(rd_stage), .rd_pc(b_rd_pc), .rd_instr(b_rd_instr),
        .rd_valid(b_rd_valid), .state(b_state), .count(b_count), .trig_idx(b_trig_idx)
    );

    function automatic logic [31:0] exp_instr(input logic [31:0] p, input int k);
        logic [3:0] kk;
        kk = 4'(k);
        return {4'hA, kk, p[23:0]};
    endfunction

    function automatic logic [STAGES*XLEN-1:0] mk_stage(input logic [31:0] p);
        logic [STAGES*XLEN-1:0] s;
        for (int k = 0; k < STAGES; k++) begin
            s[k*XLEN +: XLEN] = exp_instr(p, k);
        end
        return s;
    endfunction

    function automatic logic [1:0] cur_state(input int which);
        return (which == 0) ? a_state : b_state;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic add_vec(input int dut, input int phase, input logic [3:0] addr,
                           input logic [1:0] stg, input logic [31:0] p,
                           input logic chk_data, input logic valid);
        vec_t v;
        v.dut = dut; v.phase = phase; v.addr = addr; v.stg = stg;
        v.pc = p; v.chk_data = chk_data; v.valid = valid;
        tbl.push_back(v);
    endtask

    // Feed pc=0,4,8,... one sample per cycle until the chosen DUT reports DONE.
    task automatic feed_until_done(input int which, input logic use_force,
                                   input logic [31:0] force_pc, output int n);
        n = 40;
        for (int i = 0; i < 40; i++) begin
            pc          = 32'(4 * i);
            stage_instr = mk_stage(pc);
            force_trig  = use_force && (pc == force_pc);
            sample_en   = 1'b1;
            step();
            if (cur_state(which) == 2'd3) begin
                n = i + 1;
                break;
            end
        end
        sample_en  = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic apply_phase(input int phase);
        logic [31:0] g_pc, g_instr;
        logic        g_valid;
        foreach (tbl[i]) begin
            if (tbl[i].phase == phase) begin
                rd_addr  = tbl[i].addr;
                rd_stage = tbl[i].stg;
                step();
                g_pc    = (tbl[i].dut == 0) ? a_rd_pc    : b_rd_pc;
                g_instr = (tbl[i].dut == 0) ? a_rd_instr : b_rd_instr;
                g_valid = (tbl[i].dut == 0) ? a_rd_valid : b_rd_valid;
                check($sformatf("p%0d_valid[%0d]", phase, i), 32'(g_valid), 32'(tbl[i].valid));
                if (tbl[i].chk_data) begin
                    check($sformatf("p%0d_pc[%0d]", phase, i), g_pc, tbl[i].pc);
                    check($sformatf("p%0d_instr[%0d]", phase, i), g_instr,
                          exp_instr(tbl[i].pc, int'(tbl[i].stg)));
                end
            end
        end
    endtask

    initial begin
        int n;

        // Phase 1: basic capture, DUT A, trig_pc=0x40.
        add_vec(0, 1, 4'd0,  2'd0, 32'h24, 1, 1);
        add_vec(0, 1, 4'd7,  2'd0, 32'h40, 1, 1);
        add_vec(0, 1, 4'd15, 2'd0, 32'h60, 1, 1);
        add_vec(0, 1, 4'd1,  2'd2, 32'h28, 1, 1);
        add_vec(0, 1, 4'd15, 2'd3, 32'h60, 1, 1);
        add_vec(0, 1, 4'd8,  2'd1, 32'h44, 1, 1);
        // Phase 2: early trigger, DUT A, trig_pc=0x08.
        add_vec(0, 2, 4'd0,  2'd0, 32'h00, 1, 1);
        add_vec(0, 2, 4'd2,  2'd0, 32'h08, 1, 1);
        add_vec(0, 2, 4'd10, 2'd1, 32'h28, 1, 1);
        add_vec(0, 2, 4'd11, 2'd0, 32'h00, 0, 0);
        add_vec(0, 2, 4'd15, 2'd0, 32'h00, 0, 0);
        // Phase 3: force trigger, DUT B (no post-trigger samples).
        add_vec(1, 3, 4'd8,  2'd0, 32'h20, 1, 1);
        add_vec(1, 3, 4'd0,  2'd0, 32'h00, 1, 1);
        add_vec(1, 3, 4'd9,  2'd0, 32'h00, 0, 0);
        // Phase 4: gated samples, DUT A, stage select.
        add_vec(0, 4, 4'd0,  2'd3, 32'h00, 1, 1);
        add_vec(0, 4, 4'd3,  2'd3, 32'h18, 1, 1);
        add_vec(0, 4, 4'd5,  2'd3, 32'h28, 1, 1);
        add_vec(0, 4, 4'd1,  2'd0, 32'h08, 1, 1);
        add_vec(0, 4, 4'd6,  2'd3, 32'h00, 0, 0);

        // Reset state, with edges seen while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",    32'(a_state),    32'd0);
        check("rst_count",    32'(a_count),    32'd0);
        check("rst_trig_idx", 32'(a_trig_idx), 32'd0);
        check("rst_rd_pc",    a_rd_pc,         32'd0);
        check("rst_rd_instr", a_rd_instr,      32'd0);
        check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        reset = 1'b1;
        step();

        // IDLE ignores samples.
        sample_en = 1'b1;
        repeat (3) step();
        sample_en = 1'b0;
        check("idle_count", 32'(a_count), 32'd0);
        check("idle_state", 32'(a_state), 32'd0);

        // Basic capture.
        trig_en = 1'b1;
        trig_pc = 32'h40;
        pulse_arm();
        check("arm_state", 32'(a_state), 32'd1);
        feed_until_done(0, 1'b0, 32'h0, n);
        check("basic_done_samples", 32'(n), 32'd25);
        check("basic_state", 32'(a_state),    32'd3);
        check("basic_count", 32'(a_count),    32'd16);
        check("basic_trig_idx", 32'(a_trig_idx), 32'd7);
        apply_phase(1);

        // Re-arm from DONE, then early trigger.
        pulse_arm();
        check("rearm_state", 32'(a_state), 32'd1);
        check("rearm_count", 32'(a_count), 32'd0);
        trig_pc = 32'h08;
        feed_until_done(0, 1'b0, 32'h0, n);
        check("early_done_samples", 32'(n), 32'd11);
        check("early_count", 32'(a_count), 32'd11);
        check("early_trig_idx", 32'(a_trig_idx), 32'd2);
        apply_phase(2);

        // Force trigger with no post-trigger samples.
        trig_en = 1'b0;
        pulse_arm();
        feed_until_done(1, 1'b1, 32'h20, n);
        check("force_done_samples", 32'(n), 32'd9);
        check("force_state", 32'(b_state), 32'd3);
        check("force_count", 32'(b_count), 32'd9);
        check("force_trig_idx", 32'(b_trig_idx), 32'd8);
        apply_phase(3);

        // Gated samples: only even cycles are enabled.
        pulse_arm();
        for (int i = 0; i < 12; i++) begin
            pc          = 32'(4 * i);
            stage_instr = mk_stage(pc);
            sample_en   = (i % 2 == 0);
            step();
        end
        sample_en = 1'b0;
        check("gated_count", 32'(a_count), 32'd6);
        check("gated_state", 32'(a_state), 32'd1);
        apply_phase(4);

        // Arm together with a matching trigger: arm wins, nothing recorded.
        trig_en     = 1'b1;
        trig_pc     = 32'h100;
        pc          = 32'h100;
        stage_instr = mk_stage(pc);
        sample_en   = 1'b1;
        arm         = 1'b1;
        step();
        arm       = 1'b0;
        sample_en = 1'b0;
        check("coll_state", 32'(a_state), 32'd1);
        check("coll_count", 32'(a_count), 32'd0);
        rd_addr = 4'd0;
        step();
        check("coll_rd_valid", 32'(a_rd_valid), 32'd0);

        // Enter POST, then drop reset between clock edges.
        trig_pc = 32'h08;
        for (int i = 0; i < 5; i++) begin
            pc          = 32'(4 * i);
            stage_instr = mk_stage(pc);
            sample_en   = 1'b1;
            step();
        end
        sample_en = 1'b0;
        check("post_state", 32'(a_state), 32'd2);
        check("post_count", 32'(a_count), 32'd5);
        rd_addr = 4'd0;
        step();
        check("post_rd_valid", 32'(a_rd_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state",    32'(a_state),    32'd0);
        check("async_rst_count",    32'(a_count),    32'd0);
        check("async_rst_rd_valid", 32'(a_rd_valid), 32'd0);
        step();
        reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable trace-capture unit for the pipelined CPU, the in-silicon successor to the stage-by-stage instruction monitor used in simulation. Every enabled cycle it records the PC plus the instruction word held in each of `STAGES` pipeline registers (IF/ID … MEM/WB) into a circular buffer of `DEPTH` entries. It arms on command, triggers on a PC match or a force input, and captures a programmable number of post-trigger samples. It then freezes and exposes the captured window through a registered read port.

## Interface
- `XLEN`, 32: width of PC and instruction words.
- `STAGES`, 4: number of pipeline-register instruction taps (≥1).
- `DEPTH`, 16: buffer entries; power of two, ≥2.
- `POST_TRIG`, 8: samples captured after the trigger sample; 0 ≤ `POST_TRIG` ≤ `DEPTH-1`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `arm`  in  1  one-cycle pulse: clear the buffer and start recording.
- `sample_en`  in  1  the current cycle is a valid sample (pipeline advanced).
- `trig_en`  in  1  enables the PC-match trigger.
- `trig_pc`  in  XLEN  PC value that fires the trigger.
- `force_trig`  in  1  unconditional trigger while ARMED.
- `pc`  in  XLEN  current fetch PC.
- `stage_instr`  in  STAGES*XLEN  stage instructions; slice k is stage k, and k=0 is IF/ID.
- `rd_addr`  in  $clog2(DEPTH)  read index; 0 is the oldest captured sample.
- `rd_stage`  in  $clog2(STAGES) (min 1)  stage slice to return.
- `rd_pc`  out  XLEN  PC of the addressed entry (registered).
- `rd_instr`  out  XLEN  selected stage instruction of the addressed entry (registered).
- `rd_valid`  out  1  the registered read hit a captured entry.
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- `count`  out  $clog2(DEPTH)+1  number of valid entries, saturating at `DEPTH`.
- `trig_idx`  out  $clog2(DEPTH)  read index of the trigger sample, valid in DONE.

## Operation
- **IDLE:** no writes. `arm` moves to ARMED; `wr_ptr`=0, `count`=0.
- **ARMED:** each `sample_en` cycle writes {pc, stage_instr} at `wr_ptr`, increments `wr_ptr` (wrapping mod `DEPTH`) and increments `count` (saturating).
- **Trigger condition:** (`trig_en` & `pc`==`trig_pc`) | `force_trig`, qualified by `sample_en`. On a trigger, that sample is written and the post counter is loaded with `POST_TRIG`.
  - If `POST_TRIG`=0 the next state is DONE; otherwise POST.
- **POST:** each `sample_en` write decrements the post counter. The write that brings it to 0 moves the block to DONE. Trigger inputs are ignored.
- **DONE:** writes are frozen. `arm` restarts capture (to ARMED, with the buffer cleared).
- **Arm priority:** `arm` in any state restarts capture. `arm` wins over a trigger or write in the same cycle, and that cycle's sample is not recorded.
- **Read mapping:** physical address = (`base` + `rd_addr`) mod `DEPTH`.
  - `base` = `wr_ptr` once `count`==`DEPTH`, else 0.
  - `rd_valid` = `rd_addr` < `count`.
  - Reads are legal in every state. Reads during ARMED/POST return live, possibly changing, data.
- **trig_idx:** the trigger sample's physical slot mapped through the same `base`.

## Timing
- **Reset:** `state`=IDLE, `count`=0, `trig_idx`=0, `rd_pc`=0, `rd_instr`=0, `rd_valid`=0, and the post counter is cleared. RAM contents are don't-care.
- **Reset mid-capture:** the block returns to IDLE immediately and asynchronously; there is no partial-capture recovery.
- **`arm`:** `state` reads ARMED the cycle after the `arm` edge, and the first write can occur in that cycle.
- **Write:** occurs on the edge that samples `sample_en`=1. `count` and `state` reflect the write one cycle later.
- **DONE:** observed the cycle after the final post-trigger write.
- **Read latency:** exactly 1 cycle from `rd_addr`/`rd_stage` to `rd_pc`/`rd_instr`/`rd_valid`.
- **Write-read collision:** a read of the slot being written in the same cycle returns the old data.
- **Trigger with `count` < `DEPTH`:** pre-trigger history is simply shorter than `DEPTH-1-POST_TRIG`. This is not an error.

## Structure
- **Package `pipe_trace_pkg`:** state encoding (IDLE/ARMED/POST/DONE) and the 2-bit state type.
- **Sub-module `trace_ram`:** simple dual-port RAM (one write port, one registered read port), `DEPTH` × (`XLEN` + `STAGES`·`XLEN`). The stage mux follows the RAM read register.

## Test plan
- **Basic capture:** `DEPTH`=16, `POST_TRIG`=8, arm, then feed pc=0x00,0x04,… every cycle, with `trig_pc`=0x40.
  - DONE 9 samples after pc 0x40 is written; `count`=16.
  - `rd_addr` 0 returns pc 0x24; `trig_idx`=7; `rd_addr` 15 returns pc 0x60.
- **Early trigger:** as above but `trig_pc`=0x08.
  - `count`=11; `rd_addr` 0 returns pc 0x00; `trig_idx`=2; `rd_valid`=0 for `rd_addr` 11–15.
- **Force trigger with `POST_TRIG`=0:** pulse `force_trig` at pc 0x20.
  - DONE the next cycle; the last valid entry is pc 0x20.
- **Gated samples and stage select:** toggle `sample_en` 1/0.
  - Only enabled cycles are stored.
  - `rd_stage`=3 returns the MEM/WB word recorded with each PC.
- **Arm collision and re-arm:** assert `arm` together with a matching trigger.
  - The result is ARMED with `count`=0 and nothing recorded.
  - Re-arm from DONE clears `count`.
- **Reset mid-POST:** drop `reset` low asynchronously during POST.
  - `state`=IDLE, `count`=0, `rd_valid`=0 without waiting for a clock edge.
